// File: rtl/pwm_duty_gen_if.sv
// pwm_duty_gen_if: control inputs and PWM status outputs of pwm_duty_gen
interface pwm_duty_gen_if;
  logic       Enable;
  logic [7:0] Prescale;
  logic [7:0] DutyIn;
  logic       PwmOut;
  logic       PeriodStart;
  logic [7:0] DutyApplied;
  modport master (output Enable, Prescale, DutyIn, input PwmOut, PeriodStart, DutyApplied);
  modport slave (input Enable, Prescale, DutyIn, output PwmOut, PeriodStart, DutyApplied);
endinterface

// File: rtl/pwm_duty_gen.sv
// pwm_duty_gen: prescaled 8-bit PWM with duty shadowed at each period wrap; PWM_DUTY_GEN_SLEW_EN steps duty by 1 per wrap
module pwm_duty_gen #(
  parameter int POLARITY = 1
) (
  input logic Clock,
  input logic Resetn,
  pwm_duty_gen_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic ACT = (POLARITY != 0);
  state_t state;
  logic [7:0] pre_q, pre_d, cnt_q, cnt_d, duty_q, duty_d, slew;
  logic pwm_q, pwm_d, ps_q, ps_d, tick, wrap;
`ifdef PWM_DUTY_GEN_SLEW_EN
  assign slew = duty_q < bus.DutyIn ? duty_q + 8'd1 : duty_q > bus.DutyIn ? duty_q - 8'd1 : duty_q;
`else
  assign slew = bus.DutyIn;
`endif
  // Enable selects the state whose actions this edge performs, so a drop or raise acts on the very next edge
  always_comb begin
    state = bus.Enable ? RUN : IDLE;
    tick = (state == RUN) && (pre_q >= bus.Prescale);
    wrap = tick && (cnt_q == 8'hff);
    pre_d = (state == IDLE || tick) ? 8'd0 : pre_q + 8'd1;
    cnt_d = (state == IDLE) ? 8'd0 : cnt_q + {7'd0, tick};
    duty_d = (state == IDLE) ? bus.DutyIn : wrap ? slew : duty_q;
    ps_d = wrap;
    pwm_d = (state == RUN && cnt_q < duty_q) ? ACT : ~ACT;
  end
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      pre_q <= 8'd0;
      cnt_q <= 8'd0;
      duty_q <= 8'd0;
      ps_q <= 1'b0;
      pwm_q <= ~ACT;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      duty_q <= duty_d;
      ps_q <= ps_d;
      pwm_q <= pwm_d;
    end
  end
  assign bus.PwmOut = pwm_q;
  assign bus.PeriodStart = ps_q;
  assign bus.DutyApplied = duty_q;
endmodule

// File: tb/tb_pwm_duty_gen.sv
// tb_pwm_duty_gen: directed self-checking bench for pwm_duty_gen (active-high instance plus active-low shadow instance)
module tb_pwm_duty_gen;
  logic clk, rst_n;
  int checks = 0, errors = 0;
  pwm_duty_gen_if bus ();
  pwm_duty_gen_if bus0 ();
  assign bus0.Enable = bus.Enable;
  assign bus0.Prescale = bus.Prescale;
  assign bus0.DutyIn = bus.DutyIn;
  pwm_duty_gen #(.POLARITY(1)) dut (.Clock(clk), .Resetn(rst_n), .bus(bus));
  pwm_duty_gen #(.POLARITY(0)) dut0 (.Clock(clk), .Resetn(rst_n), .bus(bus0));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [7:0] nd(input logic [7:0] cur, input logic [7:0] tgt);
`ifdef PWM_DUTY_GEN_SLEW_EN
    return cur < tgt ? cur + 8'd1 : cur > tgt ? cur - 8'd1 : cur;
`else
    return tgt;
`endif
  endfunction
  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    bus.Enable = 1'b0;
    bus.Prescale = 8'd0;
    bus.DutyIn = 8'd77;
    rst_n = 1'b0;
    tick_n(2);
    checks++; if (bus.PwmOut !== 1'b0) begin errors++; $display("FAIL reset_pwm got %b want 0", bus.PwmOut); end
    checks++; if (bus0.PwmOut !== 1'b1) begin errors++; $display("FAIL reset_pwm_lowpol got %b want 1", bus0.PwmOut); end
    checks++; if (bus.PeriodStart !== 1'b0) begin errors++; $display("FAIL reset_ps got %b want 0", bus.PeriodStart); end
    checks++; if (bus.DutyApplied !== 8'd0) begin errors++; $display("FAIL reset_duty got %0d want 0", bus.DutyApplied); end
    rst_n = 1'b1;
  endtask
  task automatic test_basic();
    int hi = 0, hi0 = 0, ps_n = 0, ps_at = -1;
    logic [7:0] d;
    bus.Enable = 1'b1;
    bus.Prescale = 8'd0;
    bus.DutyIn = 8'd64;
    do_reset();
    for (int i = 1; i <= 256; i++) begin
      @(negedge clk);
      hi += int'(bus.PwmOut);
      if (bus.PeriodStart) begin ps_n++; ps_at = i; end
    end
    d = nd(8'd0, 8'd64);
    checks++; if (hi != 0) begin errors++; $display("FAIL basic_first_period_active got %0d want 0", hi); end
    checks++; if (ps_n != 1 || ps_at != 256) begin errors++; $display("FAIL basic_first_ps got n=%0d at=%0d want n=1 at=256", ps_n, ps_at); end
    checks++; if (bus.DutyApplied !== d) begin errors++; $display("FAIL basic_duty_after_wrap got %0d want %0d", bus.DutyApplied, d); end
    hi = 0; ps_n = 0;
    for (int i = 1; i <= 256; i++) begin
      @(negedge clk);
      hi += int'(bus.PwmOut);
      hi0 += int'(!bus0.PwmOut);
      if (bus.PeriodStart) ps_n++;
      if (i == 1) begin
        checks++; if (bus.PwmOut !== (d != 0)) begin errors++; $display("FAIL basic_first_count_active got %b want %b", bus.PwmOut, d != 0); end
      end
    end
    checks++; if (hi != int'(d)) begin errors++; $display("FAIL basic_active_count got %0d want %0d", hi, d); end
    checks++; if (hi0 != int'(d)) begin errors++; $display("FAIL basic_active_count_lowpol got %0d want %0d", hi0, d); end
    checks++; if (ps_n != 1 || bus.PeriodStart !== 1'b1) begin errors++; $display("FAIL basic_second_ps got n=%0d last=%b want n=1 last=1", ps_n, bus.PeriodStart); end
  endtask
  task automatic test_prescale();
    int hi = 0, ps_n = 0, ps1 = -1, ps2 = -1;
    logic [7:0] d;
    bus.Enable = 1'b1;
    bus.Prescale = 8'd3;
    bus.DutyIn = 8'd128;
    do_reset();
    for (int i = 1; i <= 2048; i++) begin
      @(negedge clk);
      if (i > 1024) hi += int'(bus.PwmOut);
      if (bus.PeriodStart) begin
        ps_n++;
        if (ps1 < 0) ps1 = i; else ps2 = i;
      end
    end
    d = nd(8'd0, 8'd128);
    checks++; if (ps_n != 2 || ps1 != 1024 || ps2 != 2048) begin errors++; $display("FAIL prescale_ps got n=%0d at %0d,%0d want n=2 at 1024,2048", ps_n, ps1, ps2); end
    checks++; if (hi != 4 * int'(d)) begin errors++; $display("FAIL prescale_active got %0d want %0d", hi, 4 * int'(d)); end
  endtask
  task automatic test_midperiod();
    int hi = 0;
    logic [7:0] d1, d2;
    bus.Enable = 1'b1;
    bus.Prescale = 8'd0;
    bus.DutyIn = 8'd64;
    do_reset();
    tick_n(356);
    d1 = nd(8'd0, 8'd64);
    bus.DutyIn = 8'd200;
    tick_n(155);
    checks++; if (bus.DutyApplied !== d1) begin errors++; $display("FAIL mid_duty_held got %0d want %0d", bus.DutyApplied, d1); end
    tick_n(1);
    d2 = nd(d1, 8'd200);
    checks++; if (bus.DutyApplied !== d2 || bus.PeriodStart !== 1'b1) begin errors++; $display("FAIL mid_duty_at_wrap got %0d ps=%b want %0d ps=1", bus.DutyApplied, bus.PeriodStart, d2); end
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      hi += int'(bus.PwmOut);
    end
    checks++; if (hi != int'(d2)) begin errors++; $display("FAIL mid_active_count got %0d want %0d", hi, d2); end
  endtask
  task automatic test_extremes();
    int hi = 0;
    logic last = 1'b1;
    bus.Enable = 1'b1;
    bus.Prescale = 8'd0;
    bus.DutyIn = 8'd0;
    do_reset();
    for (int i = 0; i < 768; i++) begin
      @(negedge clk);
      hi += int'(bus.PwmOut);
    end
    checks++; if (hi != 0) begin errors++; $display("FAIL duty0_active got %0d want 0", hi); end
    bus.Enable = 1'b0;
    bus.DutyIn = 8'd255;
    tick_n(1);
    checks++; if (bus.DutyApplied !== 8'd255) begin errors++; $display("FAIL idle_load got %0d want 255", bus.DutyApplied); end
    bus.Enable = 1'b1;
    hi = 0;
    for (int i = 1; i <= 256; i++) begin
      @(negedge clk);
      hi += int'(bus.PwmOut);
      if (i == 256) last = bus.PwmOut;
    end
    checks++; if (hi != 255 || last !== 1'b0) begin errors++; $display("FAIL duty255 got active=%0d last=%b want active=255 last=0", hi, last); end
  endtask
  task automatic test_enable_drop();
    int ps_at = -1;
    bus.Prescale = 8'd0;
    bus.DutyIn = 8'd100;
    bus.Enable = 1'b0;
    do_reset();
    tick_n(1);
    bus.Enable = 1'b1;
    tick_n(50);
    checks++; if (bus.PwmOut !== 1'b1) begin errors++; $display("FAIL drop_pre_active got %b want 1", bus.PwmOut); end
    bus.Enable = 1'b0;
    tick_n(1);
    checks++; if (bus.PwmOut !== 1'b0 || bus.PeriodStart !== 1'b0) begin errors++; $display("FAIL drop_idle got pwm=%b ps=%b want 0 0", bus.PwmOut, bus.PeriodStart); end
    bus.Enable = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      @(negedge clk);
      if (bus.PeriodStart && ps_at < 0) ps_at = i;
    end
    checks++; if (ps_at != 256) begin errors++; $display("FAIL reenable_wrap got %0d want 256", ps_at); end
    tick_n(1);
    checks++; if (bus.PwmOut !== 1'b1 || bus.DutyApplied !== nd(8'd100, 8'd100)) begin errors++; $display("FAIL pre_async_state got pwm=%b duty=%0d want 1 100", bus.PwmOut, bus.DutyApplied); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.PwmOut !== 1'b0 || bus0.PwmOut !== 1'b1 || bus.DutyApplied !== 8'd0 || bus.PeriodStart !== 1'b0) begin
      errors++; $display("FAIL async_reset got pwm=%b pwm0=%b duty=%0d ps=%b want 0 1 0 0", bus.PwmOut, bus0.PwmOut, bus.DutyApplied, bus.PeriodStart);
    end
    bus.Enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick_n(1);
    checks++; if (bus.DutyApplied !== 8'd100) begin errors++; $display("FAIL resume_after_reset got %0d want 100", bus.DutyApplied); end
  endtask
  task automatic test_slew();
    logic [7:0] d;
    bus.Prescale = 8'd0;
    bus.DutyIn = 8'd10;
    bus.Enable = 1'b0;
    do_reset();
    tick_n(1);
    checks++; if (bus.DutyApplied !== 8'd10) begin errors++; $display("FAIL slew_start got %0d want 10", bus.DutyApplied); end
    bus.DutyIn = 8'd13;
    bus.Enable = 1'b1;
    for (int w = 1; w <= 4; w++) begin
      tick_n(256);
`ifdef PWM_DUTY_GEN_SLEW_EN
      d = (w < 3) ? 8'(10 + w) : 8'd13;
`else
      d = 8'd13;
`endif
      checks++; if (bus.DutyApplied !== d) begin errors++; $display("FAIL slew_wrap%0d got %0d want %0d", w, bus.DutyApplied, d); end
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_prescale();
    test_midperiod();
    test_extremes();
    test_enable_drop();
    test_slew();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
